// File: rtl/uart_tx_cfg_if.sv
// Frame-request bus of the configurable UART transmitter: payload, per-frame
// line configuration and the valid/ready handshake.
interface uart_tx_cfg_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) ();
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        data_len;
    logic [1:0]        parity_mode;
    logic              stop2;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output baud_div, data_len, parity_mode, stop2, tx_data, tx_valid,
        input  tx_ready
    );

    modport slave (
        input  baud_div, data_len, parity_mode, stop2, tx_data, tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (5..DATA_W data bits, none/even/odd
// parity, 1/2 stop bits) with a zero-gap valid/ready frame handshake.
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_cfg_if.slave tx_if,
    output logic         rs232_Tx,
    output logic         tx_done,
    output logic         busy
);
    localparam int IDX_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        calc_parity = (^d) ^ odd;
    endfunction

    state_t            state_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] shift_r;
    logic              line_r;
    logic              done_r;
    logic              busy_r;

    logic [DIV_W-1:0]  div_r;
    logic [IDX_W-1:0]  last_idx_r;
    logic              par_en_r;
    logic              par_bit_r;
    logic              stop2_r;

    logic [IDX_W-1:0]  len_s;
    logic [DATA_W-1:0] masked_s;
    logic [IDX_W-1:0]  stop_last_s;
    logic              bit_end_s;
    logic              almost_end_s;
    logic              div_zero_s;
    logic              last_stop_s;
    logic              ready_s;
    logic              accept_s;

    assign stop_last_s  = {{(IDX_W-1){1'b0}}, stop2_r};
    assign bit_end_s    = (cnt_r == div_r);
    assign almost_end_s = (cnt_r != div_r) && ((cnt_r + DIV_W'(1)) == div_r);
    assign div_zero_s   = (div_r == {DIV_W{1'b0}});
    assign last_stop_s  = (state_r == STOP) && bit_end_s && (idx_r == stop_last_s);
    assign ready_s      = !rst && ((state_r == IDLE) || last_stop_s);
    assign accept_s     = tx_if.tx_valid && ready_s;

    assign tx_if.tx_ready = ready_s;
    assign rs232_Tx       = line_r;
    assign tx_done        = done_r;
    assign busy           = busy_r;

    // Clamp the requested length and drop payload bits that will not be sent.
    always_comb begin
        len_s    = IDX_W'(DATA_W);
        masked_s = {DATA_W{1'b0}};
        if ((tx_if.data_len >= 4'd5) && (tx_if.data_len <= 4'(DATA_W))) begin
            len_s = IDX_W'(tx_if.data_len);
        end else begin
            len_s = IDX_W'(DATA_W);
        end
        for (int i = 0; i < DATA_W; i++) begin
            masked_s[i] = tx_if.tx_data[i] & (i < int'(len_s));
        end
    end

    // Per-frame configuration, frozen at the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r      <= {DIV_W{1'b0}};
            last_idx_r <= {IDX_W{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            stop2_r    <= 1'b0;
        end else if (accept_s) begin
            div_r      <= tx_if.baud_div;
            last_idx_r <= len_s - IDX_W'(1);
            par_en_r   <= (tx_if.parity_mode == 2'b01) || (tx_if.parity_mode == 2'b10);
            par_bit_r  <= calc_parity(masked_s, tx_if.parity_mode == 2'b10);
            stop2_r    <= tx_if.stop2;
        end else begin
            div_r      <= div_r;
            last_idx_r <= last_idx_r;
            par_en_r   <= par_en_r;
            par_bit_r  <= par_bit_r;
            stop2_r    <= stop2_r;
        end
    end

    // Frame sequencer; line, busy and tx_done are registered, so tx_done is
    // raised on the edge that enters the last cycle of the final stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
            line_r  <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= START;
                        cnt_r   <= {DIV_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        shift_r <= masked_s;
                        line_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        line_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_r <= DATA;
                        cnt_r   <= {DIV_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        line_r  <= shift_r[0];
                        shift_r <= shift_r >> 1;
                    end else begin
                        cnt_r   <= cnt_r + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= {DIV_W{1'b0}};
                        if (idx_r == last_idx_r) begin
                            idx_r <= {IDX_W{1'b0}};
                            if (par_en_r) begin
                                state_r <= PARITY;
                                line_r  <= par_bit_r;
                            end else begin
                                state_r <= STOP;
                                line_r  <= 1'b1;
                                done_r  <= !stop2_r && div_zero_s;
                            end
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            line_r  <= shift_r[0];
                            shift_r <= shift_r >> 1;
                        end
                    end else begin
                        cnt_r <= cnt_r + DIV_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_r <= STOP;
                        cnt_r   <= {DIV_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        line_r  <= 1'b1;
                        done_r  <= !stop2_r && div_zero_s;
                    end else begin
                        cnt_r   <= cnt_r + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        cnt_r <= {DIV_W{1'b0}};
                        if (idx_r == stop_last_s) begin
                            idx_r <= {IDX_W{1'b0}};
                            if (accept_s) begin
                                // Zero-gap hand-over straight into the next start bit.
                                state_r <= START;
                                shift_r <= masked_s;
                                line_r  <= 1'b0;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                line_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            idx_r  <= idx_r + IDX_W'(1);
                            done_r <= div_zero_s;
                        end
                    end else begin
                        cnt_r  <= cnt_r + DIV_W'(1);
                        done_r <= (idx_r == stop_last_s) && almost_end_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {DIV_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    line_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
